// File: rtl/glitch_trig_delay_if.sv
// glitch_trig_delay_if: control/status bundle between the glitcher controller and the trigger front-end
// master drives edge_sel, delay, hold, arm, disarm; slave returns trig_o, armed, busy, done.
// With GLITCH_TRIG_REPEAT_EN defined, adds repeats (master to slave) and shots (slave to master).
interface glitch_trig_delay_if #(
  parameter int DELAY_W = 16,
  parameter int HOLD_W = 16
);
  logic edge_sel;
  logic [DELAY_W-1:0] delay;
  logic [HOLD_W-1:0] hold;
  logic arm;
  logic disarm;
  logic trig_o;
  logic armed;
  logic busy;
  logic done;
`ifdef GLITCH_TRIG_REPEAT_EN
  logic [7:0] repeats;
  logic [7:0] shots;
  modport master(output edge_sel, delay, hold, arm, disarm, repeats, input trig_o, armed, busy, done, shots);
  modport slave(input edge_sel, delay, hold, arm, disarm, repeats, output trig_o, armed, busy, done, shots);
`else
  modport master(output edge_sel, delay, hold, arm, disarm, input trig_o, armed, busy, done);
  modport slave(input edge_sel, delay, hold, arm, disarm, output trig_o, armed, busy, done);
`endif
endinterface

// File: rtl/glitch_trig_delay.sv
// glitch_trig_delay: armed edge trigger on trig_in, delayed and held in target-clock edges, driving trig_o
// clk/rst: glitch clock and synchronous active-high reset; target_clk, trig_in: asynchronous, synchronized here.
// bus (slave): edge_sel/delay/hold latched on arm, disarm aborts; trig_o, armed, busy, done are registered.
// GLITCH_TRIG_REPEAT_EN: adds bus.repeats/bus.shots for automatic re-arming after each shot.
module glitch_trig_delay #(
  parameter int DELAY_W = 16,
  parameter int HOLD_W = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  input logic target_clk,
  input logic trig_in,
  glitch_trig_delay_if.slave bus
);
  localparam int CW = DELAY_W > HOLD_W ? DELAY_W : HOLD_W;
  typedef enum logic [2:0] {IDLE, ARMED, DELAY, FIRE, RELEASE} st_t;
  st_t st;
  logic [SYNC_STAGES-1:0] tc_s, ti_s;
  logic tc_d, ti_d, e_l;
  logic [CW-1:0] cnt, d_l, h_l;
  logic tc_q, ti_q, tgt_rise, ev;
  logic [CW-1:0] cnt_n;
  assign tc_q = tc_s[SYNC_STAGES-1];
  assign ti_q = ti_s[SYNC_STAGES-1];
  assign tgt_rise = tc_q & ~tc_d;
  assign ev = e_l ? ti_d & ~ti_q : ti_q & ~ti_d;
  assign cnt_n = cnt + CW'(1);
`ifdef GLITCH_TRIG_REPEAT_EN
  logic [7:0] r_l, shots_n;
  assign shots_n = bus.shots + 8'd1;
`endif
  always_ff @(posedge clk) begin
    bus.done <= 1'b0;
    tc_s <= {tc_s[SYNC_STAGES-2:0], target_clk};
    ti_s <= {ti_s[SYNC_STAGES-2:0], trig_in};
    tc_d <= tc_q;
    ti_d <= ti_q;
    if (rst) begin
      tc_s <= '0;
      ti_s <= '0;
      tc_d <= 1'b0;
      ti_d <= 1'b0;
      st <= IDLE;
      cnt <= '0;
      e_l <= 1'b0;
      d_l <= '0;
      h_l <= '0;
      bus.trig_o <= 1'b0;
      bus.armed <= 1'b0;
      bus.busy <= 1'b0;
`ifdef GLITCH_TRIG_REPEAT_EN
      r_l <= '0;
      bus.shots <= '0;
`endif
    end else if (bus.disarm) begin
      st <= IDLE;
      cnt <= '0;
      bus.trig_o <= 1'b0;
      bus.armed <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      case (st)
        IDLE: if (bus.arm) begin
          e_l <= bus.edge_sel;
          d_l <= CW'(bus.delay);
          h_l <= bus.hold == '0 ? CW'(1) : CW'(bus.hold);
`ifdef GLITCH_TRIG_REPEAT_EN
          r_l <= bus.repeats == 8'd0 ? 8'd1 : bus.repeats;
          bus.shots <= '0;
`endif
          st <= ARMED;
          bus.armed <= 1'b1;
        end
        ARMED: if (ev) begin
          cnt <= '0;
          bus.armed <= 1'b0;
          bus.busy <= 1'b1;
          st <= d_l == '0 ? FIRE : DELAY;
          bus.trig_o <= d_l == '0;
        end
        DELAY: if (tgt_rise) begin
          cnt <= cnt_n == d_l ? '0 : cnt_n;
          st <= cnt_n == d_l ? FIRE : DELAY;
          bus.trig_o <= cnt_n == d_l;
        end
        FIRE: if (tgt_rise) begin
          cnt <= cnt_n == h_l ? '0 : cnt_n;
          st <= cnt_n == h_l ? RELEASE : FIRE;
          bus.trig_o <= cnt_n != h_l;
        end
        RELEASE: if (tgt_rise) begin
          // two target rising edges with trig_o low let the target-domain FSM see the release
          cnt <= cnt[0] ? '0 : cnt_n;
          if (cnt[0]) begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
`ifdef GLITCH_TRIG_REPEAT_EN
            bus.shots <= shots_n;
            st <= shots_n < r_l ? ARMED : IDLE;
            bus.armed <= shots_n < r_l;
`else
            st <= IDLE;
`endif
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_glitch_trig_delay.sv
// tb_glitch_trig_delay: randomized scoreboard bench predicting trig_o edges and done pulses from target-edge arithmetic
module tb_glitch_trig_delay;
  localparam int PER = 10;
  localparam int PH = 3;
  localparam int SS = 2;
  localparam int L = SS + 1;
  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_DONE = 2;
  typedef struct {
    int kind;
    int cyc;
  } ev_t;
  ev_t sb[$];
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic target_clk = 1'b0;
  logic trig_in = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  glitch_trig_delay_if #(.DELAY_W(16), .HOLD_W(16)) bus();
  glitch_trig_delay #(.DELAY_W(16), .HOLD_W(16), .SYNC_STAGES(SS)) dut (
    .clk(clk),
    .rst(rst),
    .target_clk(target_clk),
    .trig_in(trig_in),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial forever begin
    @(negedge clk);
    target_clk = ((cyc + PER - PH) % PER) < PER / 2;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, got cycle %0d, required end before it", cyc);
    $fatal(1);
  end
  function automatic int rise(int x, int n);
    return PH + PER * ((x - PH) / PER + n);
  endfunction
  function automatic void push_shot(int e, int d, int h);
    int rc, fc;
    rc = d == 0 ? e : rise(e, d);
    fc = rise(rc, h == 0 ? 1 : h);
    sb.push_back('{K_RISE, rc + L});
    sb.push_back('{K_FALL, fc + L});
    sb.push_back('{K_DONE, rise(fc, 2) + L});
  endfunction
  task automatic chk1(string nm, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  task automatic evt(int k);
    ev_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected no event", k, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d", k, cyc, e.kind, e.cyc);
      end
    end
  endtask
  initial begin
    logic p;
    p = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.trig_o != p) evt(bus.trig_o ? K_RISE : K_FALL);
      p = bus.trig_o;
      if (bus.done) evt(K_DONE);
    end
  end
  task automatic tick(int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic pulse_arm(logic es, int d, int h);
    bus.edge_sel = es;
    bus.delay = d[15:0];
    bus.hold = h[15:0];
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask
  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: got %0d pending events, expected 0", sb.size());
      sb.delete();
    end
  endtask
  task automatic shot(logic es, int d, int h);
    trig_in = es;
    tick(6);
    pulse_arm(es, d, h);
    chk1("armed_after_arm", bus.armed, 1'b1);
    tick(int'($urandom_range(1, 20)));
    trig_in = ~es;
    push_shot(cyc, d, h);
    tick(L + 1);
    chk1("busy_in_shot", bus.busy, 1'b1);
    wait_empty();
    chk1("armed_after_shot", bus.armed, 1'b0);
    chk1("busy_after_shot", bus.busy, 1'b0);
    chk1("trig_after_shot", bus.trig_o, 1'b0);
  endtask
  initial begin
    int e, n;
    bus.arm = 1'b0;
    bus.disarm = 1'b0;
    bus.edge_sel = 1'b0;
    bus.delay = '0;
    bus.hold = '0;
`ifdef GLITCH_TRIG_REPEAT_EN
    bus.repeats = '0;
`endif
    tick(5);
    chk1("rst_trig_o", bus.trig_o, 1'b0);
    chk1("rst_armed", bus.armed, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
`ifdef GLITCH_TRIG_REPEAT_EN
    chk("rst_shots", int'(bus.shots), 0);
`endif
    rst = 1'b0;
    repeat (60) begin
      trig_in = 1'($urandom_range(0, 1));
      tick(int'($urandom_range(1, 4)));
    end
    chk1("idle_armed", bus.armed, 1'b0);
    chk1("idle_busy", bus.busy, 1'b0);
    shot(1'b0, 3, 2);
    trig_in = 1'b0;
    tick(6);
    pulse_arm(1'b1, 0, 0);
    chk1("level_armed", bus.armed, 1'b1);
    tick(30);
    trig_in = 1'b1;
    tick(20);
    chk1("level_no_fire", bus.busy, 1'b0);
    trig_in = 1'b0;
    push_shot(cyc, 0, 0);
    wait_empty();
    chk1("level_done_armed", bus.armed, 1'b0);
    trig_in = 1'b0;
    tick(6);
    pulse_arm(1'b0, 100, 2);
    tick(5);
    trig_in = 1'b1;
    e = cyc;
    while (cyc < rise(e, 50) + L) tick();
    chk1("abort_busy_before", bus.busy, 1'b1);
    bus.disarm = 1'b1;
    tick();
    bus.disarm = 1'b0;
    chk1("abort_armed", bus.armed, 1'b0);
    chk1("abort_busy", bus.busy, 1'b0);
    chk1("abort_trig", bus.trig_o, 1'b0);
    chk1("abort_done", bus.done, 1'b0);
    while (cyc < rise(e, 100) + L + 50) tick();
    chk1("abort_stays_idle", bus.busy, 1'b0);
    shot(1'b1, 2, 1);
    trig_in = 1'b0;
    tick(6);
    bus.disarm = 1'b1;
    pulse_arm(1'b0, 1, 1);
    bus.disarm = 1'b0;
    chk1("arm_disarm_armed", bus.armed, 1'b0);
    tick(3);
    trig_in = 1'b1;
    tick(40);
    chk1("arm_disarm_busy", bus.busy, 1'b0);
    trig_in = 1'b0;
    tick(6);
    pulse_arm(1'b0, 1, 3);
    tick(2);
    trig_in = 1'b1;
    push_shot(cyc, 1, 3);
    n = 0;
    while (!bus.trig_o && n < 500) begin
      tick();
      n++;
    end
    chk1("fire_reached", bus.trig_o, 1'b1);
    bus.hold = 16'd1;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    chk1("fire_rearm_busy", bus.busy, 1'b1);
    chk1("fire_rearm_armed", bus.armed, 1'b0);
    wait_empty();
    chk1("fire_rearm_after", bus.armed, 1'b0);
    for (int i = 0; i < 8; i++)
      shot(1'($urandom_range(0, 1)), int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
`ifdef GLITCH_TRIG_REPEAT_EN
    trig_in = 1'b0;
    tick(6);
    bus.repeats = 8'd3;
    pulse_arm(1'b0, 1, 1);
    chk("shots_cleared", int'(bus.shots), 0);
    for (int i = 0; i < 3; i++) begin
      tick(int'($urandom_range(2, 8)));
      trig_in = 1'b1;
      push_shot(cyc, 1, 1);
      tick(15);
      trig_in = 1'b0;
      wait_empty();
      chk("shots_count", int'(bus.shots), i + 1);
      chk1("rearmed", bus.armed, i < 2);
    end
    tick(5);
    trig_in = 1'b1;
    tick(100);
    chk1("repeat_over_armed", bus.armed, 1'b0);
    chk("repeat_over_shots", int'(bus.shots), 3);
    trig_in = 1'b0;
    bus.repeats = '0;
`endif
    tick(10);
    chk("queue_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
